// File: rtl/id_ex_pipe_reg_pkg.sv
// id_ex_pipe_reg_pkg: shared ID/EX payload layout macros and skid-buffer state type
`ifndef ID_EX_DEFINES_SVH
`define ID_EX_DEFINES_SVH
`define InstIDDepth       16
`define ID_EX_W           128
`define ID_EX_PC_LSB      0
`define ID_EX_OPCODE_LSB  32
`define ID_EX_RS1_LSB     39
`define ID_EX_RS2_LSB     44
`define ID_EX_RD_LSB      49
`define ID_EX_RD_VLD_LSB  54
`define ID_EX_IMM_LSB     55
`define ID_EX_INSTID_LSB  87
`define ID_EX_CSR_LSB     91
`define ID_EX_CSR_VLD_LSB 103
`endif

package id_ex_pipe_reg_pkg;
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } skid_state_t;
endpackage

// File: rtl/id_ex_pipe_reg.sv
// id_ex_pipe_reg: decode-to-execute register with one skid entry and saturating stall counter
//   clk, rst_n (sync, active-low), flush kills held entries
//   in_valid/in_ready/in_data  : decode side, in_ready registered (= no skid entry)
//   out_valid/out_ready/out_data : execute side, all outputs registered
//   stall_cnt : cycles with out_valid & ~out_ready, saturating, survives flush
module id_ex_pipe_reg
    import id_ex_pipe_reg_pkg::*;
#(
    parameter int DATA_W = `ID_EX_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt
);
    skid_state_t       state;
    logic [DATA_W-1:0] skid_q;
    logic              accept;
    logic              consume;

    assign accept  = in_valid & in_ready;
    assign consume = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            out_data  <= '0;
            skid_q    <= '0;
            stall_cnt <= '0;
        end else begin
            if (out_valid && !out_ready && stall_cnt != '1)
                stall_cnt <= stall_cnt + 1'b1;
            // flush drops only the valid bits; payload registers keep their contents
            if (flush) begin
                state     <= ST_EMPTY;
                out_valid <= 1'b0;
                in_ready  <= 1'b1;
            end else begin
                case (state)
                    ST_EMPTY: if (accept) begin
                        out_data  <= in_data;
                        out_valid <= 1'b1;
                        state     <= ST_ONE;
                    end
                    ST_ONE: if (accept && consume) begin
                        out_data <= in_data;
                    end else if (consume) begin
                        out_valid <= 1'b0;
                        state     <= ST_EMPTY;
                    end else if (accept) begin
                        // execute stalled: park the new payload so in_ready never depends on out_ready
                        skid_q   <= in_data;
                        in_ready <= 1'b0;
                        state    <= ST_FULL;
                    end
                    ST_FULL: if (consume) begin
                        out_data <= skid_q;
                        in_ready <= 1'b1;
                        state    <= ST_ONE;
                    end
                    default: begin
                        state     <= ST_EMPTY;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// tb_id_ex_pipe_reg: queue-model check of the ID/EX skid register with directed and random traffic
module tb_id_ex_pipe_reg;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [127:0] in_data = '0;
    logic         in_ready, out_valid, in_ready_s, out_valid_s;
    logic [127:0] out_data, out_data_s;
    logic [15:0]  stall_cnt;
    logic [3:0]   stall_cnt_s;

    logic [127:0] q[$];
    int           cnt = 0;
    int           n_cmp = 0;
    int           n_err = 0;

    always #5 clk = ~clk;

    id_ex_pipe_reg #(.DATA_W(128), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .stall_cnt(stall_cnt)
    );

    id_ex_pipe_reg #(.DATA_W(128), .CNT_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_s),
        .in_data(in_data), .out_valid(out_valid_s), .out_ready(out_ready), .out_data(out_data_s),
        .stall_cnt(stall_cnt_s)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input bit rn, input bit fl, input bit iv, input logic [127:0] d, input bit ordy);
        bit rdy, vld;
        rst_n = rn; flush = fl; in_valid = iv; in_data = d; out_ready = ordy;
        @(posedge clk);
        rdy = q.size() < 2;
        vld = q.size() > 0;
        if (!rn) begin
            q.delete();
            cnt = 0;
        end else begin
            if (vld && !ordy && cnt < 65535) cnt++;
            if (fl) q.delete();
            else begin
                if (vld && ordy) void'(q.pop_front());
                if (iv && rdy) q.push_back(d);
            end
        end
        #1;
        check("in_ready", in_ready, q.size() < 2);
        check("out_valid", out_valid, q.size() > 0);
        if (q.size() > 0) check("out_data", out_data, q[0]);
        check("stall_cnt", stall_cnt, cnt);
        check("stall_sat", stall_cnt_s, cnt > 15 ? 15 : cnt);
        check("sat_out_valid", out_valid_s, out_valid);
    endtask

    function automatic logic [127:0] rnd();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        step(0, 0, 1, rnd(), 1);
        check("reset_out_data", out_data, 128'h0);
        step(1, 0, 1, 128'hA5, 1);
        check("first_a5", out_data, 128'hA5);
        for (int i = 1; i <= 8; i++) step(1, 0, 1, 128'(i), 1);
        step(1, 0, 0, '0, 1);
        for (int i = 1; i <= 3; i++) step(1, 0, 1, 128'(i), 0);
        step(1, 0, 1, 128'd3, 0);
        check("bp_in_ready_low", in_ready, 1'b0);
        step(1, 0, 1, 128'd3, 1);
        step(1, 0, 0, '0, 1);
        step(1, 0, 0, '0, 1);
        step(1, 0, 1, 128'h11, 0);
        step(1, 0, 1, 128'h22, 0);
        step(1, 1, 1, 128'h33, 1);
        check("flush_in_ready", in_ready, 1'b1);
        check("flush_out_valid", out_valid, 1'b0);
        step(1, 0, 1, 128'h44, 0);
        for (int i = 0; i < 20; i++) step(1, 0, 0, '0, 0);
        check("sat_hold", stall_cnt_s, 4'hF);
        step(1, 0, 1, 128'h55, 0);
        step(1, 0, 1, 128'h66, 0);
        step(0, 0, 1, 128'h77, 1);
        check("rst_mid_data", out_data, 128'h0);
        check("rst_mid_cnt", stall_cnt, 16'h0);
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 199) != 0, $urandom_range(0, 49) == 0,
                 $urandom_range(0, 3) != 0, rnd(), $urandom_range(0, 2) != 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/id_ex_pipe_reg.md
ID_EX_PIPE_REG -- requirements
Module: id_ex_pipe_reg

Interface
REQ-001 Parameter: DATA_W, default 128, width of the flattened decode payload (pc, opcode, rs1/rs2/rd, rd_vld, imm, instID, csr, csr_vld).
REQ-002 Parameter: CNT_W, default 16, width of the stall performance counter.
REQ-003 Port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port: rst_n  input  1  reset; synchronous and active-low.
REQ-005 Port: flush  input  1  kill all held entries (branch/trap redirect).
REQ-006 Port: in_valid  input  1  upstream (decode) presents a payload.
REQ-007 Port: in_ready  output  1  stage can accept; driven directly from a register.
REQ-008 Port: in_data  input  DATA_W  decode payload.
REQ-009 Port: out_valid  output  1  payload available to execute.
REQ-010 Port: out_ready  input  1  execute consumes the payload.
REQ-011 Port: out_data  output  DATA_W  registered payload to execute.
REQ-012 Port: stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0, saturating.

Function
REQ-013 Transfers SHALL occur only on valid&ready at the same edge, on each side independently.
REQ-014 Storage SHALL be a main register plus one skid register, with states EMPTY (none valid), ONE (main valid), FULL (main and skid valid).
REQ-015 in_ready SHALL equal NOT skid_valid, registered, with no combinational path from out_ready.
REQ-016 EMPTY + accept SHALL load main and go to ONE; out_valid SHALL rise the next cycle (latency 1).
REQ-017 ONE + accept + consume SHALL reload main with in_data and stay in ONE (full throughput, 1 transfer/cycle).
REQ-018 ONE + consume, no accept SHALL go to EMPTY; ONE + accept, no consume SHALL write skid and go to FULL.
REQ-019 FULL + consume SHALL move skid into main and go to ONE; accept is impossible in FULL since in_ready=0.
REQ-020 out_data and out_valid SHALL stay stable while out_valid=1 and out_ready=0.
REQ-021 Ordering SHALL be strict FIFO; no payload SHALL be dropped or duplicated except on flush.
REQ-022 flush=1 SHALL force EMPTY at the next edge, overriding any simultaneous accept or consume; in_ready SHALL be 1 in the following cycle.
REQ-023 Payload registers SHALL load only on accept or on skid-to-main move; a flush SHALL clear only the valid bits.
REQ-024 stall_cnt SHALL increment by 1 each cycle with out_valid=1 and out_ready=0, hold at 2^CNT_W-1, and not clear on flush.

Reset
REQ-025 With rst_n=0 at an edge, state SHALL be EMPTY, out_valid=0, in_ready=1, out_data=0, skid data=0 and stall_cnt=0.
REQ-026 Reset SHALL take priority over flush and all handshakes; in-flight payloads are discarded.
REQ-027 in_ready SHALL be 1 in the first cycle after rst_n returns to 1.

Structure
REQ-028 The ID_EX payload width and the field offsets within in_data SHALL be macros in the shared defines include, next to InstIDDepth.
REQ-029 The module SHALL be a single flat module with no sub-module; the skid logic SHALL be inline.
REQ-030 The module SHALL contain no combinational path from in_* to out_* or from out_ready to in_ready.

Verification
REQ-031 Reset, then in_valid=1 with in_data=0x..A5 and out_ready=1 -> out_valid=1 and out_data=0x..A5 one cycle later; in_ready stays 1.
REQ-032 Streaming: 8 back-to-back payloads 1..8 with out_ready=1 constant -> out_data 1..8 on 8 consecutive cycles, no bubble.
REQ-033 Back-pressure: out_ready=0 while sending 1,2,3 -> accepts 1 and 2, in_ready=0 at 3; release -> outputs 1,2,3 in order; stall_cnt equals the number of stall cycles.
REQ-034 Flush in FULL with simultaneous in_valid=1 -> out_valid=0 and in_ready=1 next cycle; flushed payloads never appear.
REQ-035 Saturation with CNT_W=4 and 20 stall cycles -> stall_cnt=15 and holds.
REQ-036 rst_n=0 asserted mid-stream in FULL -> all outputs at reset values next cycle; traffic after release is clean.
